// File: rtl/time_event_sched_if.sv
// Bus bundle for time_event_sched: time input, command write port, status and event outputs.
// The master drives time and commands; the slave is the scheduler itself.
interface time_event_sched_if #(
  parameter int DEPTH = 8,
  parameter int PW    = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clr;
  logic [31:0]   tq;
  logic          wr_en;
  logic [31:0]   wr_time;
  logic [PW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          ev_stb;
  logic [PW-1:0] ev_data;
  logic [31:0]   ev_time;
  logic          ev_late;
  logic          ovf;
  logic [15:0]   late_cnt;

  modport master (
    output clr, tq, wr_en, wr_time, wr_data,
    input  full, empty, count, ev_stb, ev_data, ev_time, ev_late, ovf, late_cnt
  );

  modport slave (
    input  clr, tq, wr_en, wr_time, wr_data,
    output full, empty, count, ev_stb, ev_data, ev_time, ev_late, ovf, late_cnt
  );
endinterface

// File: rtl/time_event_sched.sv
// Time-tagged event scheduler: queues (time, payload) commands and fires a one-cycle
// strobe when the registered time counter reaches the head command's target time.
module time_event_sched #(
  parameter int DEPTH = 8,
  parameter int PW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  time_event_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ARMED, FIRE} state_t;

  state_t        state;
  logic [31:0]   tq_r;
  logic [31:0]   mem_time [DEPTH];
  logic [PW-1:0] mem_data [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_nxt;
  logic [AW:0]   rd_ptr_nxt;
  logic [AW:0]   count_nxt;
  logic [31:0]   head_time;
  logic [PW-1:0] head_data;
  logic [31:0]   diff;
  logic          due;
  logic          push;
  logic          pop;

  // Modulo-2^32 difference keeps the due test correct across counter wrap.
  always_comb begin
    head_time  = mem_time[rd_ptr[AW-1:0]];
    head_data  = mem_data[rd_ptr[AW-1:0]];
    diff       = tq_r - head_time;
    due        = !bus.empty && !diff[31];
    push       = bus.wr_en && !bus.full && !bus.clr;
    pop        = (state == ARMED) && due && !bus.clr;
    wr_ptr_nxt = push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wr_ptr[AW-1:0]] <= bus.wr_time;
      mem_data[wr_ptr[AW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    tq_r <= bus.tq;
    if (rst) begin
      state        <= ARMED;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.count    <= '0;
      bus.full     <= 1'b0;
      bus.empty    <= 1'b1;
      bus.ovf      <= 1'b0;
      bus.ev_stb   <= 1'b0;
      bus.ev_late  <= 1'b0;
      bus.ev_data  <= '0;
      bus.ev_time  <= '0;
      bus.late_cnt <= '0;
    end else begin
      // The late counter tracks strobes already issued, so a flush does not suppress it.
      if (bus.ev_stb && bus.ev_late && bus.late_cnt != 16'hFFFF)
        bus.late_cnt <= bus.late_cnt + 16'd1;

      if (bus.clr) begin
        state     <= ARMED;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        bus.count <= '0;
        bus.full  <= 1'b0;
        bus.empty <= 1'b1;
        bus.ovf   <= 1'b0;
        bus.ev_stb <= 1'b0;
      end else begin
        if (bus.wr_en && bus.full)
          bus.ovf <= 1'b1;
        wr_ptr     <= wr_ptr_nxt;
        rd_ptr     <= rd_ptr_nxt;
        bus.count  <= count_nxt;
        bus.full   <= (count_nxt == (AW+1)'(DEPTH));
        bus.empty  <= (count_nxt == '0);
        bus.ev_stb <= 1'b0;
        // FIRE is a one-cycle gap so the due test sees the advanced head.
        case (state)
          ARMED: begin
            if (due) begin
              bus.ev_stb  <= 1'b1;
              bus.ev_data <= head_data;
              bus.ev_time <= head_time;
              bus.ev_late <= (diff != 32'd0);
              state       <= FIRE;
            end
          end
          FIRE:    state <= ARMED;
          default: state <= ARMED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_time_event_sched.sv
// Directed self-checking bench for time_event_sched with hand-computed expectations.
module tb_time_event_sched;
  logic clk;
  logic rst;
  int   assert_cnt;
  int   fail_cnt;
  int   stb_seen;

  time_event_sched_if #(.DEPTH(8), .PW(16)) bus ();

  time_event_sched #(.DEPTH(8), .PW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge, where inputs also change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] t, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_time = t;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    assert_cnt  = 0;
    fail_cnt    = 0;
    rst         = 1'b1;
    bus.clr     = 1'b0;
    bus.tq      = 32'd95;
    bus.wr_en   = 1'b0;
    bus.wr_time = '0;
    bus.wr_data = '0;
    tick();
    tick();
    rst = 1'b0;
    $display("[TB] reset values");
    check_output("rst_full", 64'(bus.full), 64'd0);
    check_output("rst_empty", 64'(bus.empty), 64'd1);
    check_output("rst_count", 64'(bus.count), 64'd0);
    check_output("rst_ev_stb", 64'(bus.ev_stb), 64'd0);
    check_output("rst_ev_late", 64'(bus.ev_late), 64'd0);
    check_output("rst_ev_data", 64'(bus.ev_data), 64'd0);
    check_output("rst_ev_time", 64'(bus.ev_time), 64'd0);
    check_output("rst_ovf", 64'(bus.ovf), 64'd0);
    check_output("rst_late_cnt", 64'(bus.late_cnt), 64'd0);

    $display("[TB] in-time fire");
    apply_stimulus(32'd100, 16'hA5A5);
    check_output("t1_count", 64'(bus.count), 64'd1);
    stb_seen = 0;
    for (int t = 95; t <= 105; t++) begin
      bus.tq = 32'(t);
      tick();
      check_output("t1_stb", 64'(bus.ev_stb), 64'(t == 101));
      if (bus.ev_stb) stb_seen++;
      if (t == 101) begin
        check_output("t1_data", 64'(bus.ev_data), 64'hA5A5);
        check_output("t1_time", 64'(bus.ev_time), 64'd100);
        check_output("t1_late", 64'(bus.ev_late), 64'd0);
      end
    end
    check_output("t1_stb_total", 64'(stb_seen), 64'd1);
    check_output("t1_empty", 64'(bus.empty), 64'd1);

    $display("[TB] late fire");
    bus.tq = 32'd500;
    tick();
    apply_stimulus(32'd300, 16'h0001);
    check_output("t2_stb_w", 64'(bus.ev_stb), 64'd0);
    tick();
    check_output("t2_stb_w1", 64'(bus.ev_stb), 64'd1);
    check_output("t2_late", 64'(bus.ev_late), 64'd1);
    check_output("t2_data", 64'(bus.ev_data), 64'h0001);
    check_output("t2_time", 64'(bus.ev_time), 64'd300);
    tick();
    check_output("t2_late_cnt", 64'(bus.late_cnt), 64'd1);

    $display("[TB] time wrap");
    bus.tq = 32'hFFFF_FFFE;
    tick();
    apply_stimulus(32'h0000_0001, 16'h0BEE);
    for (int i = 0; i < 5; i++) begin
      bus.tq = 32'hFFFF_FFFF + 32'(i);
      tick();
      check_output("t3_stb", 64'(bus.ev_stb), 64'(i == 3));
      if (i == 3) begin
        check_output("t3_late", 64'(bus.ev_late), 64'd0);
        check_output("t3_data", 64'(bus.ev_data), 64'h0BEE);
      end
    end
    check_output("t3_late_cnt", 64'(bus.late_cnt), 64'd1);

    $display("[TB] full and overflow");
    bus.tq = 32'd0;
    tick();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(32'd1000, 16'(16'h0100 + i));
      if (i == 7) begin
        check_output("t4_full8", 64'(bus.full), 64'd1);
        check_output("t4_ovf8", 64'(bus.ovf), 64'd0);
      end
    end
    check_output("t4_full", 64'(bus.full), 64'd1);
    check_output("t4_count", 64'(bus.count), 64'd8);
    check_output("t4_ovf", 64'(bus.ovf), 64'd1);
    bus.tq = 32'd1000;
    tick();
    stb_seen = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      check_output("t4_stb", 64'(bus.ev_stb), 64'((i % 2 == 0) && i < 16));
      if (bus.ev_stb) begin
        stb_seen++;
        check_output("t4_order", 64'(bus.ev_data), 64'(16'h0100 + i / 2));
      end
    end
    check_output("t4_stb_total", 64'(stb_seen), 64'd8);
    check_output("t4_empty", 64'(bus.empty), 64'd1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check_output("t4_ovf_clr", 64'(bus.ovf), 64'd0);

    $display("[TB] clear mid-queue");
    for (int i = 0; i < 3; i++)
      apply_stimulus(32'd2000, 16'(16'h00C0 + i));
    check_output("t5_count3", 64'(bus.count), 64'd3);
    bus.tq = 32'd2000;
    tick();
    tick();
    check_output("t5_stb", 64'(bus.ev_stb), 64'd1);
    check_output("t5_data", 64'(bus.ev_data), 64'h00C0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check_output("t5_count", 64'(bus.count), 64'd0);
    check_output("t5_empty", 64'(bus.empty), 64'd1);
    stb_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ev_stb) stb_seen++;
      tick();
    end
    check_output("t5_no_stb", 64'(stb_seen), 64'd0);
    check_output("t5_held_data", 64'(bus.ev_data), 64'h00C0);
    check_output("t5_late_cnt", 64'(bus.late_cnt), 64'd1);

    $display("[TB] write while full with same-cycle pop");
    bus.tq = 32'd0;
    tick();
    for (int i = 0; i < 8; i++)
      apply_stimulus(32'd3000, 16'(16'h0200 + i));
    check_output("t6_full", 64'(bus.full), 64'd1);
    check_output("t6_ovf0", 64'(bus.ovf), 64'd0);
    bus.tq = 32'd3000;
    tick();
    apply_stimulus(32'd3000, 16'hDEAD);
    check_output("t6_stb", 64'(bus.ev_stb), 64'd1);
    check_output("t6_data", 64'(bus.ev_data), 64'h0200);
    check_output("t6_ovf", 64'(bus.ovf), 64'd1);
    check_output("t6_count", 64'(bus.count), 64'd7);
    check_output("t6_not_full", 64'(bus.full), 64'd0);
    stb_seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_output("t6_drain_stb", 64'(bus.ev_stb), 64'((i % 2 == 1) && i <= 13));
      if (bus.ev_stb) begin
        stb_seen++;
        check_output("t6_drain_order", 64'(bus.ev_data), 64'(16'h0200 + (i + 1) / 2));
      end
    end
    check_output("t6_drain_total", 64'(stb_seen), 64'd7);
    check_output("t6_empty", 64'(bus.empty), 64'd1);

    $display("[TB] clear beats write");
    bus.clr = 1'b1;
    apply_stimulus(32'd9000, 16'h7777);
    bus.clr = 1'b0;
    check_output("t7_count", 64'(bus.count), 64'd0);
    check_output("t7_empty", 64'(bus.empty), 64'd1);
    check_output("t7_ovf", 64'(bus.ovf), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
